// File: rtl/core_mem_bridge.sv
// core_mem_bridge: latches one core request, strobes the memory controller
// until it responds or a bounded wait expires, then pulses ready to the core.
module core_mem_bridge #(
    parameter int                    ADDR_WIDTH     = 32,
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    TIMEOUT_CYCLES = 255,
    parameter logic [DATA_WIDTH-1:0] ERROR_DATA     = 32'hDEADBEEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  core_req,
    input  logic                  core_we,
    input  logic [ADDR_WIDTH-1:0] core_address,
    input  logic [DATA_WIDTH-1:0] core_write_data,
    output logic [DATA_WIDTH-1:0] core_read_data,
    output logic                  core_ready,
    output logic                  core_error,
    output logic                  core_busy,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    input  logic [DATA_WIDTH-1:0] mem_read_data,
    input  logic                  mem_response,
    output logic [31:0]           access_count,
    output logic [7:0]            error_count
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TLIM =
        TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam bit TMO_EN = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t                r_state;
    state_t                w_next;
    logic                  r_we;
    logic                  r_read;
    logic                  r_write;
    logic                  r_err;
    logic [TW-1:0]         r_tcnt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [31:0]           r_acc;
    logic [7:0]            r_errc;
    logic                  w_resp;
    logic                  w_tmo;

    // A response in the threshold cycle wins over the timeout.
    assign w_resp = (r_state == S_WAIT) && mem_response;
    assign w_tmo  = TMO_EN && (r_state == S_WAIT) && !mem_response
                    && (r_tcnt == TLIM);

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (core_req) w_next = S_WAIT;
            S_WAIT:  if (w_resp || w_tmo) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_we    <= 1'b0;
            r_read  <= 1'b0;
            r_write <= 1'b0;
            r_err   <= 1'b0;
            r_tcnt  <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_acc   <= '0;
            r_errc  <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (core_req) begin
                        r_we    <= core_we;
                        r_addr  <= core_address;
                        r_wdata <= core_write_data;
                        r_tcnt  <= '0;
                        r_err   <= 1'b0;
                        r_read  <= ~core_we;
                        r_write <= core_we;
                    end
                end
                S_WAIT: begin
                    r_tcnt <= r_tcnt + 1'b1;
                    if (w_resp) begin
                        r_read  <= 1'b0;
                        r_write <= 1'b0;
                        r_acc   <= r_acc + 32'd1;
                        if (!r_we) r_rdata <= mem_read_data;
                    end else if (w_tmo) begin
                        r_read  <= 1'b0;
                        r_write <= 1'b0;
                        r_err   <= 1'b1;
                        if (!r_we) r_rdata <= ERROR_DATA;
                        if (r_errc != 8'hFF) r_errc <= r_errc + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign core_busy      = (r_state != S_IDLE);
    assign core_ready     = (r_state == S_DONE);
    assign core_error     = (r_state == S_DONE) && r_err;
    assign core_read_data = r_rdata;
    assign mem_read       = r_read;
    assign mem_write      = r_write;
    assign mem_address    = r_addr;
    assign mem_write_data = r_wdata;
    assign access_count   = r_acc;
    assign error_count    = r_errc;

endmodule

// File: tb/tb_core_mem_bridge.sv
// tb_core_mem_bridge: transaction-planned stimulus with a per-cycle
// expectation derived from each access's planned response cycle.
module tb_core_mem_bridge;

    localparam int T = 4;
    localparam logic [31:0] ERR = 32'hDEADBEEF;

    logic        clk = 1'b0;
    logic        reset;
    logic        core_req;
    logic        core_we;
    logic [31:0] core_address;
    logic [31:0] core_write_data;
    logic [31:0] core_read_data;
    logic        core_ready;
    logic        core_error;
    logic        core_busy;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;
    logic        mem_response;
    logic [31:0] access_count;
    logic [7:0]  error_count;

    core_mem_bridge #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32),
        .TIMEOUT_CYCLES(T), .ERROR_DATA(ERR)
    ) dut (
        .clk(clk), .reset(reset),
        .core_req(core_req), .core_we(core_we),
        .core_address(core_address), .core_write_data(core_write_data),
        .core_read_data(core_read_data), .core_ready(core_ready),
        .core_error(core_error), .core_busy(core_busy),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_read_data(mem_read_data), .mem_response(mem_response),
        .access_count(access_count), .error_count(error_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    // Expected outputs for the current cycle
    logic        e_read, e_write, e_busy, e_ready, e_error;
    logic [31:0] m_addr, m_wdata, m_rdata, m_acc;
    logic [7:0]  m_errc;

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", n, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("mem_read", {31'b0, mem_read}, {31'b0, e_read});
            chk("mem_write", {31'b0, mem_write}, {31'b0, e_write});
            chk("core_busy", {31'b0, core_busy}, {31'b0, e_busy});
            chk("core_ready", {31'b0, core_ready}, {31'b0, e_ready});
            chk("core_error", {31'b0, core_error}, {31'b0, e_error});
            chk("mem_address", mem_address, m_addr);
            chk("mem_write_data", mem_write_data, m_wdata);
            chk("core_read_data", core_read_data, m_rdata);
            chk("access_count", access_count, m_acc);
            chk("error_count", {24'b0, error_count}, {24'b0, m_errc});
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_exp();
        e_read = 0; e_write = 0; e_busy = 0; e_ready = 0; e_error = 0;
    endtask

    task automatic noise(input bit stray);
        core_req        = 1'b0;
        core_we         = 1'($urandom);
        core_address    = $urandom;
        core_write_data = $urandom;
        mem_read_data   = $urandom;
        mem_response    = stray && ($urandom_range(0, 2) == 0);
    endtask

    task automatic model_reset();
        m_addr = 0; m_wdata = 0; m_rdata = 0; m_acc = 0; m_errc = 0;
    endtask

    task automatic idle_cycle(input bit nz);
        cyc();
        noise(nz);
        idle_exp();
    endtask

    // d = planned response cycle (1..T completes; 0 or >T times out)
    task automatic access(input bit we, input logic [31:0] a,
                          input logic [31:0] wd, input int d,
                          input logic [31:0] rsp, input bit nz);
        bit tmo;
        int endc;
        tmo  = !(d >= 1 && d <= T);
        endc = tmo ? T : d;
        cyc();
        noise(nz);
        core_req = 1; core_we = we;
        core_address = a; core_write_data = wd;
        idle_exp();
        for (int i = 1; i <= endc; i++) begin
            cyc();
            noise(1'b0);
            core_req = nz && ($urandom_range(0, 1) == 1);
            mem_response = (i == d);
            if (i == d) mem_read_data = rsp;
            m_addr = a; m_wdata = wd;
            e_busy = 1; e_read = !we; e_write = we;
            e_ready = 0; e_error = 0;
        end
        cyc();
        noise(nz);
        if (d == endc + 1) mem_response = 1;
        core_req = nz && ($urandom_range(0, 1) == 1);
        if (tmo) begin
            if (m_errc != 8'hFF) m_errc = m_errc + 8'd1;
            if (!we) m_rdata = ERR;
        end else begin
            m_acc = m_acc + 32'd1;
            if (!we) m_rdata = rsp;
        end
        e_busy = 1; e_read = 0; e_write = 0; e_ready = 1; e_error = tmo;
    endtask

    task automatic reset_mid();
        logic [31:0] a, wd;
        a = $urandom; wd = $urandom;
        cyc();
        noise(1'b0);
        core_req = 1; core_we = 0; core_address = a; core_write_data = wd;
        idle_exp();
        cyc();
        noise(1'b0);
        m_addr = a; m_wdata = wd; e_busy = 1; e_read = 1;
        cyc();
        noise(1'b0);
        reset = 1;
        cyc();
        noise(1'b0);
        reset = 0;
        model_reset();
        idle_exp();
        chk("lit_rst_busy", {31'b0, core_busy}, 32'd0);
        chk("lit_rst_read", {31'b0, mem_read}, 32'd0);
        chk("lit_rst_acc", access_count, 32'd0);
    endtask

    initial begin
        reset = 1;
        core_req = 0; core_we = 0; core_address = 0; core_write_data = 0;
        mem_read_data = 0; mem_response = 0;
        model_reset();
        idle_exp();
        repeat (3) cyc();
        chk_en = 1;
        cyc();
        reset = 0;
        noise(1'b0);

        access(0, 32'h100, 32'h0, 1, 32'h12345678, 0);
        chk("lit_rd_data", core_read_data, 32'h12345678);
        chk("lit_rd_acc", access_count, 32'd1);
        chk("lit_rd_ready", {31'b0, core_ready}, 32'd1);

        access(1, 32'h200, 32'hCAFEBABE, 3, 32'h0BAD0BAD, 0);
        chk("lit_wr_data", core_read_data, 32'h12345678);
        chk("lit_wr_acc", access_count, 32'd2);

        access(0, 32'h300, 32'h0, 0, 32'h0, 0);
        chk("lit_to_data", core_read_data, 32'hDEADBEEF);
        chk("lit_to_err", {31'b0, core_error}, 32'd1);
        chk("lit_to_errc", {24'b0, error_count}, 32'd1);
        chk("lit_to_acc", access_count, 32'd2);

        access(0, 32'h400, 32'h0, T, 32'h0000A5A5, 0);
        chk("lit_race_err", {31'b0, core_error}, 32'd0);
        chk("lit_race_errc", {24'b0, error_count}, 32'd1);
        chk("lit_race_data", core_read_data, 32'h0000A5A5);

        idle_cycle(1);
        access(1, 32'h500, 32'h55AA55AA, 2, 32'h0, 1);
        idle_cycle(1);
        idle_cycle(1);
        chk("lit_ign_acc", access_count, 32'd4);

        access(1, 32'h600, 32'h1, T + 1, 32'h0, 0);
        chk("lit_late_errc", {24'b0, error_count}, 32'd2);

        reset_mid();
        access(0, 32'h700, 32'h0, 2, 32'h77777777, 0);
        chk("lit_post_acc", access_count, 32'd1);

        for (int n = 0; n < 200; n++) begin
            access(1'($urandom), $urandom, $urandom,
                   int'($urandom_range(0, T + 1)), $urandom,
                   1'($urandom));
            if ($urandom_range(0, 2) == 0) idle_cycle(1);
        end

        for (int n = 0; n < 260; n++)
            access(1'($urandom), $urandom, $urandom, 0, 32'h0, 0);
        chk("lit_sat_errc", {24'b0, error_count}, 32'd255);

        idle_cycle(0);
        idle_cycle(0);
        chk_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
